sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one single-port synchronous SRAM between the CPU instruction-fetch port and the data (load/store) port. It sits between the pipeline's fetch/memory stages and the unified SRAM. Each cycle it grants at most one requester, drives the SRAM, and routes the one-cycle-latency read data back to whichever requester issued the read. Data accesses have priority, and a starvation counter guarantees fetch forward progress.

## Interface
- STARVE_LIMIT, 4: consecutive denied fetch cycles after which fetch wins over data (range 1..15).
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch read request.
- inst_addr  in  32  fetch byte address.
- inst_gnt  out  1  fetch request accepted this cycle.
- inst_rvalid  out  1  fetch read data valid.
- inst_rdata  out  32  fetch read data.
- data_req  in  1  data access request.
- data_wen  in  4  byte write enables; 0 means read.
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data.
- data_gnt  out  1  data request accepted this cycle.
- data_rvalid  out  1  load data valid.
- data_rdata  out  32  load data.
- sram_en  out  1  SRAM enable.
- sram_wen  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after an enabled read.

## Operation
- Grant decision is combinational within the cycle:
  - data_req alone: data granted.
  - inst_req alone: inst granted.
  - Both requesting: data granted, unless starve_cnt == STARVE_LIMIT, in which case inst is granted.
  - Neither requesting: no grant.
- At most one of inst_gnt and data_gnt is high in any cycle.
- SRAM drive:
  - sram_en = inst_gnt | data_gnt.
  - sram_addr, sram_wen and sram_wdata come from the granted requester.
  - An inst grant always drives sram_wen = 0 and sram_wdata = 0.
  - With no grant, sram_addr, sram_wen and sram_wdata are all 0.
- pending register (NONE / INST / DATA) is loaded every cycle:
  - INST on an inst grant.
  - DATA on a data grant with data_wen == 0.
  - NONE otherwise; stores and idle cycles load NONE.
- Return path:
  - inst_rvalid = (pending == INST).
  - data_rvalid = (pending == DATA).
  - When its rvalid is high, the matching rdata output equals sram_rdata combinationally, and the value is captured into a hold register.
  - When its rvalid is low, each rdata output presents its own hold register, i.e. the last delivered value.
- starve_cnt, 4 bits:
  - Increments when inst_req=1 and data_gnt=1, saturating at STARVE_LIMIT.
  - Clears when inst_gnt=1 or inst_req=0.
- Requesters must hold req, addr, wen and wdata stable until they see gnt.

## Timing
- Reset (resetn=0, asynchronous):
  - pending=NONE, starve_cnt=0, both hold registers 0.
  - All outputs 0, including sram_en, both gnt and both rvalid, since requests are gated while in reset.
- Deassertion takes effect at the first rising edge of clk with resetn=1.
- Read latency is exactly 1 cycle: a grant in cycle N gives rvalid in cycle N+1. Stores produce no rvalid.
- Back-to-back operation:
  - A new grant can issue in the same cycle a previous read returns, giving full throughput of 1 access per cycle.
  - Alternating owners each still receive their own rvalid one cycle after their grant.
- Starvation bound: with both requesters continuously active, fetch is granted at least once every STARVE_LIMIT+1 cycles.
- Reset asserted mid-read (pending != NONE): the read is dropped, with no rvalid after reset.
- Simultaneous store and fetch at the same address: the store wins, and a fetch granted later reads the new data.

## Test plan
- Reset with inst_req=1, data_req=1: all outputs 0. First cycle after release: data_gnt=1, inst_gnt=0, sram_en=1.
- Fetch only, inst_addr=0xBFC00000, SRAM word 0x3C08BFC0: inst_gnt=1 and sram_addr=0xBFC00000 in cycle N; inst_rvalid=1 and inst_rdata=0x3C08BFC0 in N+1; inst_rdata holds that value in N+2.
- Continuous inst_req and data_req (loads), STARVE_LIMIT=4: grant pattern D,D,D,D,I repeating. starve_cnt returns to 0 after every I grant.
- Store data_wen=4'b0011, addr=0x100, wdata=0x0000BEEF: sram_wen=4'b0011, sram_wdata=0x0000BEEF, and no data_rvalid the next cycle. A following load of 0x100 returns low half 0xBEEF one cycle later.
- Alternating grants I,D,I: inst_rvalid, data_rvalid, inst_rvalid appear in the respective following cycles. They are never high together and each carries its own SRAM word.
- Assert resetn=0 in the cycle after a data read grant: data_rvalid stays 0 and data_rdata reads 0 after reset.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - fetch/data arbiter for one single-port synchronous SRAM
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_LIMIT denials.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_INST = 2'd1,
    PEND_DATA = 2'd2
  } pend_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  pend_e       pending_q, pending_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] inst_hold_q, inst_hold_d;
  logic [31:0] data_hold_q, data_hold_d;
  logic        starved;

  assign starved = (starve_q == LIMIT);

  // Requests are gated by resetn so every output reads 0 while reset is held.
  assign inst_gnt = resetn & inst_req & (~data_req | starved);
  assign data_gnt = resetn & data_req & ~(inst_req & starved);

  always_comb begin
    sram_en    = inst_gnt | data_gnt;
    sram_wen   = 4'b0;
    sram_addr  = 32'b0;
    sram_wdata = 32'b0;
    if (inst_gnt) begin
      sram_addr = inst_addr;
    end else if (data_gnt) begin
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  always_comb begin
    pending_d = PEND_NONE;
    if (inst_gnt) begin
      pending_d = PEND_INST;
    end else if (data_gnt && (data_wen == 4'b0)) begin
      pending_d = PEND_DATA;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (inst_gnt || !inst_req) begin
      starve_d = 4'b0;
    end else if (data_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  assign inst_rvalid = (pending_q == PEND_INST);
  assign data_rvalid = (pending_q == PEND_DATA);

  // Returned word passes straight through and is also latched for later cycles.
  assign inst_rdata  = inst_rvalid ? sram_rdata : inst_hold_q;
  assign data_rdata  = data_rvalid ? sram_rdata : data_hold_q;
  assign inst_hold_d = inst_rdata;
  assign data_hold_d = data_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q   <= PEND_NONE;
      starve_q    <= 4'b0;
      inst_hold_q <= 32'b0;
      data_hold_q <= 32'b0;
    end else begin
      pending_q   <= pending_d;
      starve_q    <= starve_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
// Vector table for grant/drive decisions, scoreboard queue for the read return path.
module tb_sram_port_arbiter;

  localparam int unsigned SL = 4;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int errors;
  int checks;

  sram_port_arbiter #(.STARVE_LIMIT(SL)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_gnt    (inst_gnt),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wen    (data_wen),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .sram_en     (sram_en),
    .sram_wen    (sram_wen),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 256 words, contents reloaded while reset is held.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 0) ? 32'h3C08BFC0 : (32'hA500_0000 | (32'(i) * 32'h101));
    end else if (sram_en) begin
      if (sram_wen == 4'b0) begin
        sram_rdata <= mem[sram_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic        is_inst;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [3:0]  dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        eig;
    logic        edg;
    logic [3:0]  ewen;
    logic [31:0] eaddr;
    logic [31:0] ewd;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wen   = dw;
    data_addr  = da;
    data_wdata = dd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each read granted this cycle must return on its own port exactly one cycle later.
  task automatic sb_step();
    sb_t e;
    if (!resetn) begin
      sb_q.delete();
      return;
    end
    chk("gnt_exclusive", 32'(inst_gnt & data_gnt), 32'h0);
    chk("rvalid_exclusive", 32'(inst_rvalid & data_rvalid), 32'h0);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      if (e.is_inst) begin
        chk("sb_inst_rvalid", 32'(inst_rvalid), 32'h1);
        chk("sb_inst_rdata", inst_rdata, e.data);
      end else begin
        chk("sb_data_rvalid", 32'(data_rvalid), 32'h1);
        chk("sb_data_rdata", data_rdata, e.data);
      end
    end else begin
      chk("sb_no_inst_rvalid", 32'(inst_rvalid), 32'h0);
      chk("sb_no_data_rvalid", 32'(data_rvalid), 32'h0);
    end
    if (inst_gnt)
      sb_q.push_back('{1'b1, mem[inst_addr[9:2]]});
    else if (data_gnt && data_wen == 4'b0)
      sb_q.push_back('{1'b0, mem[data_addr[9:2]]});
  endtask

  task automatic sample();
    @(negedge clk);
    sb_step();
  endtask

  initial begin
    logic [31:0] ia;
    logic [31:0] da;
    logic        exp_i;
    errors = 0;
    checks = 0;

    vecs[0] = '{1'b1, 32'h10, 1'b0, 4'h0, 32'h0,  32'h0,        1'b1, 1'b0, 4'h0, 32'h10, 32'h0};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 4'h0, 32'h24, 32'h55,       1'b0, 1'b1, 4'h0, 32'h24, 32'h55};
    vecs[2] = '{1'b1, 32'h30, 1'b1, 4'h0, 32'h38, 32'h0,        1'b0, 1'b1, 4'h0, 32'h38, 32'h0};
    vecs[3] = '{1'b0, 32'h30, 1'b0, 4'hF, 32'h38, 32'h77,       1'b0, 1'b0, 4'h0, 32'h0,  32'h0};
    vecs[4] = '{1'b1, 32'h44, 1'b0, 4'hF, 32'h48, 32'hFFFFFFFF, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0};
    vecs[5] = '{1'b0, 32'h0,  1'b1, 4'h8, 32'h80, 32'hCC000000, 1'b0, 1'b1, 4'h8, 32'h80, 32'hCC000000};

    // Reset held with both requesters active.
    resetn = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    sample();
    chk("rst_inst_gnt", 32'(inst_gnt), 32'h0);
    chk("rst_data_gnt", 32'(data_gnt), 32'h0);
    chk("rst_sram_en", 32'(sram_en), 32'h0);
    chk("rst_sram_addr", sram_addr, 32'h0);
    chk("rst_inst_rvalid", 32'(inst_rvalid), 32'h0);
    chk("rst_data_rvalid", 32'(data_rvalid), 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    tick();
    resetn = 1'b1;
    sample();
    chk("rel_data_gnt", 32'(data_gnt), 32'h1);
    chk("rel_inst_gnt", 32'(inst_gnt), 32'h0);
    chk("rel_sram_en", 32'(sram_en), 32'h1);
    tick();
    idle();
    sample();
    tick();

    // Single-cycle grant/drive vectors, each followed by an idle cycle.
    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].ir, vecs[v].ia, vecs[v].dr, vecs[v].dw, vecs[v].da, vecs[v].dd);
      sample();
      chk($sformatf("v%0d_inst_gnt", v), 32'(inst_gnt), 32'(vecs[v].eig));
      chk($sformatf("v%0d_data_gnt", v), 32'(data_gnt), 32'(vecs[v].edg));
      chk($sformatf("v%0d_sram_en", v), 32'(sram_en), 32'(vecs[v].eig | vecs[v].edg));
      chk($sformatf("v%0d_sram_wen", v), 32'(sram_wen), 32'(vecs[v].ewen));
      chk($sformatf("v%0d_sram_addr", v), sram_addr, vecs[v].eaddr);
      chk($sformatf("v%0d_sram_wdata", v), sram_wdata, vecs[v].ewd);
      tick();
      idle();
      sample();
      tick();
    end

    // Fetch from reset vector: data in N+1, held in N+2.
    drive(1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    chk("fetch_gnt", 32'(inst_gnt), 32'h1);
    chk("fetch_sram_addr", sram_addr, 32'hBFC00000);
    tick();
    idle();
    sample();
    chk("fetch_rvalid_n1", 32'(inst_rvalid), 32'h1);
    chk("fetch_rdata_n1", inst_rdata, 32'h3C08BFC0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h50, 32'h0);
    sample();
    chk("fetch_rvalid_n2", 32'(inst_rvalid), 32'h0);
    chk("fetch_rdata_n2", inst_rdata, 32'h3C08BFC0);
    tick();
    idle();
    sample();
    chk("fetch_rdata_n3", inst_rdata, 32'h3C08BFC0);
    tick();

    // Continuous contention: D,D,D,D,I repeating.
    ia = 32'h200;
    da = 32'h300;
    for (int k = 0; k < 10; k++) begin
      exp_i = ((k % 5) == 4);
      drive(1'b1, ia, 1'b1, 4'h0, da, 32'h0);
      sample();
      chk($sformatf("starve%0d_inst_gnt", k), 32'(inst_gnt), 32'(exp_i));
      chk($sformatf("starve%0d_data_gnt", k), 32'(data_gnt), 32'(!exp_i));
      tick();
      if (exp_i) ia = ia + 32'h4;
      else       da = da + 32'h4;
    end
    idle();
    sample();
    tick();

    // Alternating owners I,D,I.
    drive(1'b1, 32'h60, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    chk("alt0_inst_gnt", 32'(inst_gnt), 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h64, 32'h0);
    sample();
    chk("alt1_data_gnt", 32'(data_gnt), 32'h1);
    chk("alt1_inst_rdata", inst_rdata, 32'hA5001818);
    tick();
    drive(1'b1, 32'h68, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    chk("alt2_inst_gnt", 32'(inst_gnt), 32'h1);
    chk("alt2_data_rdata", data_rdata, 32'hA5001919);
    tick();
    idle();
    sample();
    chk("alt3_inst_rdata", inst_rdata, 32'hA5001A1A);
    tick();

    // Store racing a fetch to the same word; later load and fetch see new data.
    drive(1'b1, 32'h100, 1'b1, 4'b0011, 32'h100, 32'h0000BEEF);
    sample();
    chk("st_data_gnt", 32'(data_gnt), 32'h1);
    chk("st_inst_gnt", 32'(inst_gnt), 32'h0);
    chk("st_sram_wen", 32'(sram_wen), 32'h3);
    chk("st_sram_wdata", sram_wdata, 32'h0000BEEF);
    tick();
    drive(1'b1, 32'h100, 1'b1, 4'h0, 32'h100, 32'h0);
    sample();
    chk("st_no_data_rvalid", 32'(data_rvalid), 32'h0);
    chk("ld_data_gnt", 32'(data_gnt), 32'h1);
    tick();
    drive(1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    chk("ld_low_half", data_rdata & 32'h0000FFFF, 32'h0000BEEF);
    chk("ld_word", data_rdata, 32'hA500BEEF);
    chk("late_fetch_gnt", 32'(inst_gnt), 32'h1);
    tick();
    idle();
    sample();
    chk("late_fetch_rdata", inst_rdata, 32'hA500BEEF);
    tick();

    // Reset asserted while a load is outstanding drops it.
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h40, 32'h0);
    sample();
    chk("mid_data_gnt", 32'(data_gnt), 32'h1);
    tick();
    idle();
    resetn = 1'b0;
    sample();
    chk("mid_rst_data_rvalid", 32'(data_rvalid), 32'h0);
    chk("mid_rst_data_rdata", data_rdata, 32'h0);
    tick();
    resetn = 1'b1;
    sample();
    chk("post_rst_data_rvalid", 32'(data_rvalid), 32'h0);
    chk("post_rst_data_rdata", data_rdata, 32'h0);
    chk("post_rst_inst_rdata", inst_rdata, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
